rob_retire: RTL
===============

Name: rob_retire

Overview:
- In-order commit engine at the tail of the out-of-order pipeline. It consumes ROB entries in the order the dispatcher allocates them.
- Owns the ROB head/tail pointers and occupancy count that the dispatcher reads.
- When the head entry is ready, it retires that entry: writes the register file, clears the map table mapping if it is still current, frees the slot, and halts on a retired ecall.

Parameters:
- ROB_SIZE, 16: number of ROB entries. Tags are 1..ROB_SIZE; tag 0 means "no tag".
- NUM_REGS, 32: architectural registers.
- XLEN, 32: register data width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- rob_increment  in  1  dispatcher allocates one entry at rob_tail this cycle.
- rob  in  rob_entry[ROB_SIZE]  current ROB contents; entry for tag t is rob[t-1].
- map_table  in  map_table_entry[NUM_REGS]  current rename map.
- rob_head  out  int  tag of the oldest entry, range 1..ROB_SIZE.
- rob_tail  out  int  tag given to the next allocation, range 1..ROB_SIZE.
- rob_count  out  int  occupied entries, range 0..ROB_SIZE.
- rf_we  out  1  register file write strobe.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  XLEN  register file write data.
- mt_clear  out  1  clear map_table[mt_clear_reg] back to the register file (tag=0, in_rob=0).
- mt_clear_reg  out  5  map table index to clear.
- rob_free  out  1  invalidate ROB entry rob_free_tag.
- rob_free_tag  out  int  tag being freed.
- halt  out  1  sticky; an ecall has retired.

Behaviour:
- Reset (async, reset=0):
  - rob_head=1, rob_tail=1, rob_count=0.
  - All strobes 0; rf_waddr=0, rf_wdata=0, mt_clear_reg=0, rob_free_tag=0.
  - halt=0; FSM=RUN.
  - Takes effect mid-retire: any pending strobe is dropped.
- FSM states: RUN, HALTED.
  - RUN -> HALTED when an entry with ctrl_bits.ecall retires.
  - HALTED is left only via reset.
- Retire condition, evaluated each cycle in RUN: rob_count>0 and rob[rob_head-1].ready.
  - At most one entry retires per cycle.
- Latency: the decision is made in cycle N. The registered outputs (rf_*, mt_*, rob_free*) pulse for exactly one cycle in N+1. rob_head advances at the N/N+1 edge.
- Register write: rf_we=1 when all of the following hold:
  - rd!=0;
  - ctrl_bits nonzero;
  - none of memwr, cjump, ecall, unsupported is set.
  - On a write, rf_waddr=rd and rf_wdata=value.
- ucjump entries write value (the link address) to rd.
- Unsupported entries (ctrl_bits=0, ready=1) retire silently: only rob_free pulses.
- Map table clear: mt_clear=1 iff rf_we would be 1 and map_table[rd].tag equals the retiring tag. A younger rename of rd suppresses the clear.
- rob_free pulses for every retired entry, with rob_free_tag set to the retiring tag.
- Pointer wrap: a pointer advancing from ROB_SIZE goes to 1.
- Count rules:
  - rob_increment alone: rob_count+1, rob_tail advances.
  - Retire alone: rob_count-1.
  - Both in the same cycle: rob_count unchanged, both pointers advance.
- Full: rob_increment while rob_count==ROB_SIZE and no simultaneous retire is ignored. Tail and count are unchanged.
- Empty: no retire when rob_count==0, even if rob[rob_head-1].ready is stale-high.
- HALTED behaviour:
  - No further retires; strobes stay 0.
  - rob_increment is still accepted until the ROB is full.
  - halt=1.
- The ecall entry itself is freed (rob_free pulses) on the cycle after it retires, and halt rises in that same cycle.

Optional Feature:
- Macro: ROB_RETIRE_STATS_EN.
- Defined: adds these output ports, all reset to 0:
  - retired_total (32 bits): increments on each retire.
  - rf_writes_total (32 bits): increments on each rf_we pulse.
  - full_stall_cycles (32 bits): increments each cycle rob_increment=1 is dropped because the ROB is full.
  - All three counters wrap at 2^32.
- Undefined: the ports and counters are absent, with no change to any other behaviour.

Test Plan:
- Reset, then allocate 3 entries (rob_increment high for 3 cycles), with no ready bits set -> rob_tail=4, rob_count=3, rob_head=1, no strobes.
- Set rob[0] to ready, rd=5, value=0x1234, ALU ctrl_bits, map_table[5].tag=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, mt_clear=1 with mt_clear_reg=5, rob_free_tag=1; rob_head=2, rob_count=2.
- Same as the previous scenario but map_table[5].tag=3 (younger rename) -> rf_we=1, mt_clear=0.
- Head entry is a store (memwr) or has rd=0 -> rf_we=0, rob_free=1, head advances.
- Fill to ROB_SIZE=16 and assert rob_increment again with no retire -> count stays 16, tail stays 1. Then retire and allocate in the same cycle -> count stays 16, head=2, tail=2.
- Retire an ecall at head 2 while entry 3 is ready -> halt=1 from the next cycle, entry 3 never retires. Assert reset=0 mid-run -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/rob_retire.sv
// In-order ROB retire stage: owns head/tail/count and drives RF, map-table and free strobes.
// Optional macro ROB_RETIRE_STATS_EN adds retire/write/full-stall counters.
package rob_retire_pkg;
    localparam int RV_XLEN = 32;

    typedef struct packed {
        logic alu;
        logic load;
        logic memwr;
        logic cjump;
        logic ucjump;
        logic ecall;
        logic unsupported;
    } ctrl_bits_t;

    typedef struct packed {
        logic               ready;
        logic [4:0]         rd;
        logic [RV_XLEN-1:0] value;
        ctrl_bits_t         ctrl_bits;
    } rob_entry;

    typedef struct packed {
        logic       in_rob;
        logic [7:0] tag;
    } map_table_entry;
endpackage

module rob_retire
    import rob_retire_pkg::*;
#(
    parameter int ROB_SIZE = 16,
    parameter int NUM_REGS = 32,
    parameter int XLEN     = RV_XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rob_increment,
    input  rob_entry         rob [ROB_SIZE],
    input  map_table_entry   map_table [NUM_REGS],
    output int               rob_head,
    output int               rob_tail,
    output int               rob_count,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             mt_clear,
    output logic [4:0]       mt_clear_reg,
    output logic             rob_free,
    output int               rob_free_tag,
`ifdef ROB_RETIRE_STATS_EN
    output logic [31:0]      retired_total,
    output logic [31:0]      rf_writes_total,
    output logic [31:0]      full_stall_cycles,
`endif
    output logic             halt
);
    localparam int IDX_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;

    typedef enum logic {RUN, HALTED} state_t;

    state_t          state, state_n;
    logic [IDX_W-1:0] head_idx;
    logic [4:0]      head_rd;
    ctrl_bits_t      head_c;
    logic            retire, wr, clr, accept, stall;

    function automatic int wrap_inc(int p);
        return (p == ROB_SIZE) ? 1 : p + 1;
    endfunction

    assign head_idx = IDX_W'(rob_head - 1);
    assign head_rd  = rob[head_idx].rd;
    assign head_c   = rob[head_idx].ctrl_bits;

    // A stale ready bit on an empty ROB must never retire.
    assign retire = (state == RUN) && (rob_count > 0) && rob[head_idx].ready;
    assign wr     = (head_rd != 5'd0) && (head_c != '0)
                  && !(head_c.memwr || head_c.cjump
                       || head_c.ecall || head_c.unsupported);
    // Only clear the mapping if no younger instruction renamed rd.
    assign clr    = wr && (map_table[head_rd].tag == 8'(rob_head));
    assign stall  = rob_increment && (rob_count == ROB_SIZE) && !retire;
    assign accept = rob_increment && !stall;
    assign halt   = (state == HALTED);

    always_comb begin
        state_n = state;
        unique case (1'b1)
            (state == RUN): if (retire && head_c.ecall) state_n = HALTED;
            (state == HALTED): state_n = HALTED;
            default: state_n = state;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rob_head  <= 1;
            rob_tail  <= 1;
            rob_count <= 0;
        end else begin
            if (retire) rob_head <= wrap_inc(rob_head);
            if (accept) rob_tail <= wrap_inc(rob_tail);
            if (accept && !retire) rob_count <= rob_count + 1;
            else if (retire && !accept) rob_count <= rob_count - 1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            mt_clear     <= 1'b0;
            mt_clear_reg <= '0;
            rob_free     <= 1'b0;
            rob_free_tag <= 0;
        end else begin
            rf_we    <= retire && wr;
            mt_clear <= retire && clr;
            rob_free <= retire;
            if (retire && wr) begin
                rf_waddr <= head_rd;
                rf_wdata <= XLEN'(rob[head_idx].value);
            end
            if (retire && clr) mt_clear_reg <= head_rd;
            if (retire) rob_free_tag <= rob_head;
        end
    end

`ifdef ROB_RETIRE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_total     <= '0;
            rf_writes_total   <= '0;
            full_stall_cycles <= '0;
        end else begin
            if (retire)        retired_total     <= retired_total + 32'd1;
            if (retire && wr)  rf_writes_total   <= rf_writes_total + 32'd1;
            if (stall)         full_stall_cycles <= full_stall_cycles + 32'd1;
        end
    end
`endif
endmodule
